// File: rtl/bb_bus_arbiter.sv
// Round-robin system bus arbiter with split-transaction support.
// One owner at a time, a dead turnaround cycle between owners, resumed masters first.
module bb_bus_arbiter #(
  parameter int NUM_MASTERS = 4,
  parameter int MID_W       = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_MASTERS-1:0] breq,
  output logic [NUM_MASTERS-1:0] bgrant,
  output logic [MID_W-1:0]       msel,
  output logic                   bus_busy,
  input  logic                   split_start,
  input  logic                   split_resume,
  input  logic [MID_W-1:0]       resume_id,
  output logic [NUM_MASTERS-1:0] split_pending
);

  typedef enum logic [1:0] {IDLE, GRANT, HANDOVER} state_t;

  state_t                 state;
  logic [MID_W-1:0]       ptr;
  logic [NUM_MASTERS-1:0] resume_mask;

  logic [NUM_MASTERS-1:0] eligible;
  logic [NUM_MASTERS-1:0] resume_elig;
  logic                   rs_found;
  logic [MID_W-1:0]       rs_idx;
  logic                   rr_found;
  logic [MID_W-1:0]       rr_idx;
  logic                   win_valid;
  logic [MID_W-1:0]       win_idx;
  logic [MID_W-1:0]       ptr_next;
  logic                   resume_ok;

  assign eligible    = breq & ~split_pending;
  assign resume_elig = eligible & resume_mask;

  // NOTE: every variable gets a default before the loops so no latch is inferred.
  always_comb begin
    rs_found = 1'b0;
    rs_idx   = '0;
    for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
      if (resume_elig[i]) begin
        rs_found = 1'b1;
        rs_idx   = MID_W'(i);
      end
    end

    rr_found = 1'b0;
    rr_idx   = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (!rr_found && eligible[(int'(ptr) + i) % NUM_MASTERS]) begin
        rr_found = 1'b1;
        rr_idx   = MID_W'((int'(ptr) + i) % NUM_MASTERS);
      end
    end
  end

  assign win_valid = |eligible;
  assign win_idx   = rs_found ? rs_idx : rr_idx;
  assign ptr_next  = (win_idx == MID_W'(NUM_MASTERS - 1)) ? '0 : win_idx + 1'b1;

  // The current owner is never pending, so a resume cannot collide with a split of the same bit.
  assign resume_ok = split_resume && (int'(resume_id) < NUM_MASTERS) && split_pending[resume_id];

  // NOTE: all state is updated with non-blocking assignments so every read sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      bgrant        <= '0;
      msel          <= '0;
      bus_busy      <= 1'b0;
      split_pending <= '0;
      resume_mask   <= '0;
      ptr           <= '0;
    end else begin
      if (resume_ok) begin
        split_pending[resume_id] <= 1'b0;
        resume_mask[resume_id]   <= 1'b1;
      end

      case (state)
        IDLE, HANDOVER: begin
          if (win_valid) begin
            state    <= GRANT;
            bgrant   <= NUM_MASTERS'(1) << win_idx;
            msel     <= win_idx;
            bus_busy <= 1'b1;
            ptr      <= ptr_next;
            if (rs_found) resume_mask[win_idx] <= 1'b0;
          end else begin
            state <= IDLE;
          end
        end
        GRANT: begin
          // Split takes precedence over a simultaneous release.
          if (split_start || !breq[msel]) begin
            state    <= HANDOVER;
            bgrant   <= '0;
            bus_busy <= 1'b0;
            if (split_start) split_pending[msel] <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bb_bus_arbiter.sv
// Self-checking bench for bb_bus_arbiter: directed vector table, randomized run
// against an owner/queue-level reference model, and a round-robin fairness sequence.
module tb_bb_bus_arbiter;

  localparam int N = 4;
  localparam int W = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] breq;
  logic [N-1:0] bgrant;
  logic [W-1:0] msel;
  logic         bus_busy;
  logic         split_start;
  logic         split_resume;
  logic [W-1:0] resume_id;
  logic [N-1:0] split_pending;

  int tests_run = 0;
  int tests_failed = 0;

  bb_bus_arbiter #(.NUM_MASTERS(N), .MID_W(W)) dut (
    .clk           (clk),
    .rst           (rst),
    .breq          (breq),
    .bgrant        (bgrant),
    .msel          (msel),
    .bus_busy      (bus_busy),
    .split_start   (split_start),
    .split_resume  (split_resume),
    .resume_id     (resume_id),
    .split_pending (split_pending)
  );

  always #5 clk = ~clk;

  // Reference model: who owns the bus (-1 = nobody), parked and resumed sets, RR pointer.
  int       m_owner = -1;
  bit [N-1:0] m_pend = '0;
  bit [N-1:0] m_res = '0;
  int       m_ptr = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic model_step();
    bit [N-1:0] new_pend;
    bit [N-1:0] new_res;
    bit [N-1:0] elig;
    int w;
    if (rst) begin
      m_owner = -1; m_pend = '0; m_res = '0; m_ptr = 0;
      return;
    end
    new_pend = m_pend;
    new_res  = m_res;
    if (split_resume && int'(resume_id) < N && m_pend[resume_id]) begin
      new_pend[resume_id] = 1'b0;
      new_res[resume_id]  = 1'b1;
    end
    if (m_owner >= 0) begin
      if (split_start) begin
        new_pend[m_owner] = 1'b1;
        m_owner = -1;
      end else if (!breq[m_owner]) begin
        m_owner = -1;
      end
    end else begin
      elig = breq & ~m_pend;
      w = -1;
      for (int i = 0; i < N; i++)
        if (w < 0 && elig[i] && m_res[i]) w = i;
      if (w >= 0) new_res[w] = 1'b0;
      else
        for (int k = 0; k < N; k++)
          if (w < 0 && elig[(m_ptr + k) % N]) w = (m_ptr + k) % N;
      if (w >= 0) begin
        m_owner = w;
        m_ptr = (w + 1) % N;
      end
    end
    m_pend = new_pend;
    m_res  = new_res;
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
  endtask

  function automatic int owner_of(input logic [N-1:0] g);
    int o = -1;
    for (int i = 0; i < N; i++) if (g[i]) o = i;
    return o;
  endfunction

  typedef struct {
    logic         rst;
    logic [N-1:0] breq;
    logic         ss;
    logic         sr;
    logic [W-1:0] rid;
    logic [N-1:0] eg;
    logic [W-1:0] em;
    logic         eb;
    logic [N-1:0] ep;
  } vec_t;

  vec_t vecs[22];

  initial begin
    int ord[$];
    int zeros;
    int held;
    int o;
    logic [N-1:0] exp_g;

    //         rst   breq     ss    sr    rid    bgrant   msel   busy  pending
    vecs[0]  = '{1'b1, 4'b0000, 1'b0, 1'b0, 2'd0, 4'b0000, 2'd0, 1'b0, 4'b0000};
    vecs[1]  = '{1'b0, 4'b0010, 1'b0, 1'b0, 2'd0, 4'b0010, 2'd1, 1'b1, 4'b0000};
    vecs[2]  = '{1'b0, 4'b0010, 1'b0, 1'b0, 2'd0, 4'b0010, 2'd1, 1'b1, 4'b0000};
    vecs[3]  = '{1'b0, 4'b0000, 1'b0, 1'b0, 2'd0, 4'b0000, 2'd0, 1'b0, 4'b0000};
    vecs[4]  = '{1'b0, 4'b0000, 1'b0, 1'b0, 2'd0, 4'b0000, 2'd0, 1'b0, 4'b0000};
    vecs[5]  = '{1'b0, 4'b0010, 1'b0, 1'b0, 2'd0, 4'b0010, 2'd1, 1'b1, 4'b0000};
    vecs[6]  = '{1'b0, 4'b1110, 1'b1, 1'b0, 2'd0, 4'b0000, 2'd0, 1'b0, 4'b0010};
    vecs[7]  = '{1'b0, 4'b1110, 1'b0, 1'b0, 2'd0, 4'b0100, 2'd2, 1'b1, 4'b0010};
    vecs[8]  = '{1'b0, 4'b1110, 1'b0, 1'b1, 2'd1, 4'b0100, 2'd2, 1'b1, 4'b0000};
    vecs[9]  = '{1'b0, 4'b1010, 1'b0, 1'b0, 2'd0, 4'b0000, 2'd0, 1'b0, 4'b0000};
    vecs[10] = '{1'b0, 4'b1010, 1'b0, 1'b0, 2'd0, 4'b0010, 2'd1, 1'b1, 4'b0000};
    vecs[11] = '{1'b0, 4'b1010, 1'b0, 1'b1, 2'd2, 4'b0010, 2'd1, 1'b1, 4'b0000};
    vecs[12] = '{1'b0, 4'b1000, 1'b0, 1'b0, 2'd0, 4'b0000, 2'd0, 1'b0, 4'b0000};
    vecs[13] = '{1'b0, 4'b1000, 1'b0, 1'b0, 2'd0, 4'b1000, 2'd3, 1'b1, 4'b0000};
    vecs[14] = '{1'b0, 4'b0000, 1'b1, 1'b0, 2'd0, 4'b0000, 2'd0, 1'b0, 4'b1000};
    vecs[15] = '{1'b0, 4'b0000, 1'b0, 1'b0, 2'd0, 4'b0000, 2'd0, 1'b0, 4'b1000};
    vecs[16] = '{1'b0, 4'b0100, 1'b0, 1'b0, 2'd0, 4'b0100, 2'd2, 1'b1, 4'b1000};
    vecs[17] = '{1'b0, 4'b0100, 1'b1, 1'b0, 2'd0, 4'b0000, 2'd0, 1'b0, 4'b1100};
    vecs[18] = '{1'b0, 4'b0001, 1'b0, 1'b0, 2'd0, 4'b0001, 2'd0, 1'b1, 4'b1100};
    vecs[19] = '{1'b1, 4'b0001, 1'b0, 1'b0, 2'd0, 4'b0000, 2'd0, 1'b0, 4'b0000};
    vecs[20] = '{1'b0, 4'b1000, 1'b0, 1'b0, 2'd0, 4'b1000, 2'd3, 1'b1, 4'b0000};
    vecs[21] = '{1'b0, 4'b0000, 1'b0, 1'b0, 2'd0, 4'b0000, 2'd0, 1'b0, 4'b0000};

    rst = 1'b1; breq = '0; split_start = 1'b0; split_resume = 1'b0; resume_id = '0;
    @(negedge clk);

    for (int r = 0; r < 22; r++) begin
      rst = vecs[r].rst; breq = vecs[r].breq; split_start = vecs[r].ss;
      split_resume = vecs[r].sr; resume_id = vecs[r].rid;
      step();
      check($sformatf("vec%0d bgrant", r), 32'(bgrant), 32'(vecs[r].eg));
      check($sformatf("vec%0d bus_busy", r), 32'(bus_busy), 32'(vecs[r].eb));
      check($sformatf("vec%0d split_pending", r), 32'(split_pending), 32'(vecs[r].ep));
      if (vecs[r].eb) check($sformatf("vec%0d msel", r), 32'(msel), 32'(vecs[r].em));
    end

    // Randomized run against the reference model.
    for (int c = 0; c < 2000; c++) begin
      for (int b = 0; b < N; b++)
        if ($urandom_range(7) == 0) breq[b] = ~breq[b];
      rst          = ($urandom_range(99) == 0);
      split_start  = ($urandom_range(9) == 0);
      split_resume = ($urandom_range(5) == 0);
      resume_id    = W'($urandom_range(N - 1));
      step();
      exp_g = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
      check($sformatf("rand%0d bgrant", c), 32'(bgrant), 32'(exp_g));
      check($sformatf("rand%0d bus_busy", c), 32'(bus_busy), 32'(m_owner >= 0));
      check($sformatf("rand%0d split_pending", c), 32'(split_pending), 32'(m_pend));
      if (m_owner >= 0) check($sformatf("rand%0d msel", c), 32'(msel), 32'(m_owner));
      check($sformatf("rand%0d onehot", c), 32'($countones(bgrant) <= 1), 32'd1);
    end

    // Fairness: all masters request, each owner releases after holding for 3 cycles.
    rst = 1'b1; breq = '0; split_start = 1'b0; split_resume = 1'b0;
    step();
    rst = 1'b0; breq = 4'hF;
    zeros = 0; held = 0;
    for (int c = 0; c < 60 && ord.size() < 5; c++) begin
      step();
      o = owner_of(bgrant);
      if (o >= 0) begin
        if (held == 0) begin
          if (ord.size() > 0) check($sformatf("fair gap before %0d", ord.size()), 32'(zeros), 32'd1);
          ord.push_back(o);
          zeros = 0;
        end
        held++;
        breq = (held == 3) ? (4'hF & ~(N'(1) << o)) : 4'hF;
      end else begin
        zeros++;
        held = 0;
        breq = 4'hF;
      end
    end
    check("fair grant count", 32'(ord.size()), 32'd5);
    for (int i = 0; i < ord.size() && i < 5; i++)
      check($sformatf("fair order %0d", i), 32'(ord[i]), 32'(i % N));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
